// File: rtl/matrix_loader.sv
// Weight-memory responder: streams BANDWIDTH consecutive Q2.14 words into one wide, held chunk.
// Optional feature macro: MATRIX_LOADER_ZERO_PAD_EN (pad lanes past the end with zero instead of wrapping).
module matrix_loader #(
  parameter int MAX_ROWS   = 64,
  parameter int MAX_COLS   = 64,
  parameter int BANDWIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  localparam int DEPTH     = MAX_ROWS * MAX_COLS,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            matrix_enable,
  input  logic [AW-1:0]                   matrix_addr,
  output logic [DATA_WIDTH*BANDWIDTH-1:0] matrix_data,
  output logic                            matrix_ready,
  input  logic                            load_en,
  input  logic [AW-1:0]                   load_addr,
  input  logic [DATA_WIDTH-1:0]           load_data,
  output logic                            busy
);

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_FETCH = 3'b010;
  localparam logic [2:0] S_READY = 3'b100;

  localparam int CW = $clog2(BANDWIDTH + 2);
  localparam logic [CW-1:0] BW_C   = CW'(BANDWIDTH);
  localparam logic [CW-1:0] LAST_C = CW'(BANDWIDTH + 1);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

  logic [2:0]                      state;
  logic [CW-1:0]                   cyc;
  logic [AW-1:0]                   base;
  logic [DATA_WIDTH*BANDWIDTH-1:0] staging;
  logic [DATA_WIDTH-1:0]           rd_data;
  logic [DATA_WIDTH-1:0]           mem [DEPTH];

  logic          issue;
  logic          in_range;
  logic          pad;
  logic [AW:0]   sum;
  logic [AW:0]   wrapped;

  assign busy     = (state != S_IDLE);
  assign issue    = (state == S_FETCH) && (cyc < BW_C);
  assign sum      = {1'b0, base} + (AW+1)'(cyc);
  assign in_range = (sum < DEPTH_W);
  assign wrapped  = in_range ? sum : sum - DEPTH_W;

`ifdef MATRIX_LOADER_ZERO_PAD_EN
  assign pad = !in_range;
`else
  assign pad = 1'b0;
`endif

  // NOTE: the weight array and its read register carry no reset so they map onto plain SRAM.
  always_ff @(posedge clk) begin
    if (load_en && state == S_IDLE)
      mem[load_addr] <= load_data;
    if (issue)
      rd_data <= pad ? '0 : mem[wrapped[AW-1:0]];
  end

  // cyc counts FETCH cycles: reads go out for cyc 0..BW-1, lanes land for cyc 1..BW, cyc BW+1 publishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cyc          <= '0;
      base         <= '0;
      staging      <= '0;
      matrix_data  <= '0;
      matrix_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (matrix_enable) begin
            base  <= matrix_addr;
            cyc   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!matrix_enable) begin
            state <= S_IDLE;
          end else begin
            cyc <= cyc + 1'b1;
            // Shift each lane in from the top so lane 0 ends up in the low word.
            if (cyc != '0 && cyc <= BW_C)
              staging <= {rd_data, staging[DATA_WIDTH*BANDWIDTH-1:DATA_WIDTH]};
            if (cyc == LAST_C) begin
              matrix_data  <= staging;
              matrix_ready <= 1'b1;
              state        <= S_READY;
            end
          end
        end
        S_READY: begin
          if (!matrix_enable) begin
            matrix_ready <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          matrix_ready <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader (default 64x64, 16 lanes of 16 bits).
// Build with MATRIX_LOADER_ZERO_PAD_EN defined to check the zero-padding variant.
module tb_matrix_loader;

  localparam int DEPTH = 4096;
  localparam int BW    = 16;
  localparam int DW    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              matrix_enable;
  logic [11:0]       matrix_addr;
  logic [BW*DW-1:0]  matrix_data;
  logic              matrix_ready;
  logic              load_en;
  logic [11:0]       load_addr;
  logic [DW-1:0]     load_data;
  logic              busy;

  int errors = 0;
  int checks = 0;

  matrix_loader dut (
    .clk           (clk),
    .rst           (rst),
    .matrix_enable (matrix_enable),
    .matrix_addr   (matrix_addr),
    .matrix_data   (matrix_data),
    .matrix_ready  (matrix_ready),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW*DW-1:0] obs, input logic [BW*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected chunk when memory word i holds i.
  function automatic logic [BW*DW-1:0] chunk(input int b);
    logic [BW*DW-1:0] c;
    int a;
    c = '0;
    for (int k = 0; k < BW; k++) begin
      a = b + k;
`ifdef MATRIX_LOADER_ZERO_PAD_EN
      c[k*DW +: DW] = (a >= DEPTH) ? 16'h0000 : DW'(a);
`else
      c[k*DW +: DW] = DW'(a % DEPTH);
`endif
    end
    return c;
  endfunction

  // Request at base; edge 0 is the edge after this call starts. Checks ready edges 17/18.
  task automatic fetch(input string tag, input int b, input logic [BW*DW-1:0] exp);
    matrix_enable = 1'b1;
    matrix_addr   = 12'(b);
    step();
    check({tag, "_busy"}, BW*DW'(busy), BW*DW'(1'b1));
    matrix_addr = 12'(b + 7);
    for (int n = 1; n <= 17; n++) step();
    check({tag, "_ready_c17"}, BW*DW'(matrix_ready), '0);
    step();
    check({tag, "_ready_c18"}, BW*DW'(matrix_ready), BW*DW'(1'b1));
    check({tag, "_data"}, matrix_data, exp);
  endtask

  task automatic release_req(input string tag);
    matrix_enable = 1'b0;
    step();
    check({tag, "_ready_drop"}, BW*DW'(matrix_ready), '0);
    check({tag, "_busy_drop"}, BW*DW'(busy), '0);
  endtask

  logic [BW*DW-1:0] exp_w;

  initial begin
    rst = 1'b1; matrix_enable = 1'b0; matrix_addr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    step(); step();
    check("rst_ready", BW*DW'(matrix_ready), '0);
    check("rst_data",  matrix_data, '0);
    check("rst_busy",  BW*DW'(busy), '0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1'b1; load_addr = 12'(i); load_data = DW'(i);
      step();
    end
    load_en = 1'b0;

    fetch("base0", 0, chunk(0));
    release_req("base0");
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_idle", matrix_data, chunk(0));
    end

    fetch("base4088", 4088, chunk(4088));
    release_req("base4088");

    fetch("base32", 32, chunk(32));
    release_req("base32");
    matrix_enable = 1'b1; matrix_addr = 12'd64;
    step();
    for (int n = 1; n <= 4; n++) step();
    matrix_enable = 1'b0;
    step();
    check("abort_busy",  BW*DW'(busy), '0);
    check("abort_ready", BW*DW'(matrix_ready), '0);
    check("abort_data",  matrix_data, chunk(32));
    step();
    check("abort_data_later", matrix_data, chunk(32));

    // Write during fetch is dropped.
    matrix_enable = 1'b1; matrix_addr = 12'd0;
    step(); step(); step();
    load_en = 1'b1; load_addr = 12'd5; load_data = 16'h7FFF;
    step();
    load_en = 1'b0;
    for (int n = 4; n <= 17; n++) step();
    check("wr_busy_ready_c17", BW*DW'(matrix_ready), '0);
    step();
    check("wr_busy_ready", BW*DW'(matrix_ready), BW*DW'(1'b1));
    check("wr_busy_data",  matrix_data, chunk(0));
    release_req("wr_busy");

    // Write in IDLE alongside a request is committed before the read.
    exp_w = chunk(0);
    exp_w[5*DW +: DW] = 16'h7FFF;
    load_en = 1'b1; load_addr = 12'd5; load_data = 16'h7FFF;
    matrix_enable = 1'b1; matrix_addr = 12'd0;
    step();
    load_en = 1'b0;
    for (int n = 1; n <= 18; n++) step();
    check("wr_idle_ready", BW*DW'(matrix_ready), BW*DW'(1'b1));
    check("wr_idle_data",  matrix_data, exp_w);
    release_req("wr_idle");

    // Reset in the middle of a fetch.
    matrix_enable = 1'b1; matrix_addr = 12'd64;
    step();
    for (int n = 1; n <= 9; n++) step();
    rst = 1'b1; matrix_enable = 1'b0;
    step();
    check("midrst_ready", BW*DW'(matrix_ready), '0);
    check("midrst_data",  matrix_data, '0);
    check("midrst_busy",  BW*DW'(busy), '0);
    rst = 1'b0;
    step();
    fetch("after_rst", 64, chunk(64));
    release_req("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
